rate_meter: RTL and testbench

RATE_METER -- requirements
Module: rate_meter

---
 rtl/rate_meter.sv | 147 ++++++++++++++
 tb/tb_rate_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_meter.sv
// Measures the period between rate ticks on CLOCK_50 and reports it as a speed code
// (1..10, 15 = too fast), with lock detection, timeout and a seven-segment readout.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no reference tick yet; next edge starts the period counter
//  MEASURE | classifying each period, waiting for two equal codes
//  LOCKED  | two consecutive periods gave the same code in 1..10
module rate_meter #(
    parameter int unsigned BASE_PERIOD = 800000000,
    parameter int unsigned CNT_W       = 31
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick_in,
    output logic [3:0] speed,
    output logic       locked,
    output logic       timeout,
    output logic [6:0] HEX5
);

    localparam logic [63:0]      BASE64  = 64'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'((64'd3 * BASE64) >> 1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tick_d;
    logic             tick_edge;
    logic             cnt_sat;
    logic [3:0]       code;
    logic [3:0]       speed_d;
    logic             locked_d, timeout_d;

    // Bands are [3/4 P_k, 3/2 P_k); they tile the range, so only periods above the
    // code-1 band fall through to 0, and those are caught by the timeout first.
    function automatic logic [3:0] classify(input logic [CNT_W-1:0] p);
        logic [63:0] pv;
        logic [63:0] pk;
        logic [3:0]  c;
        pv = 64'(p);
        c  = 4'd0;
        if (pv < ((64'd3 * (BASE64 >> 9)) >> 2))
            c = 4'd15;
        for (int k = 1; k <= 10; k++) begin
            pk = BASE64 >> (k - 1);
            if (pv >= ((64'd3 * pk) >> 2) && pv < ((64'd3 * pk) >> 1))
                c = 4'(k);
        end
        return c;
    endfunction

    assign tick_edge = tick_in & ~tick_d;
    assign cnt_sat   = (cnt == TIMEOUT);
    assign code      = classify(cnt);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tick_d  <= 1'b0;
            speed   <= 4'd0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            tick_d  <= tick_in;
            speed   <= speed_d;
            locked  <= locked_d;
            timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state;
        speed_d   = speed;
        locked_d  = locked;
        timeout_d = timeout;

        if (tick_edge)
            cnt_d = CNT_W'(1);
        else if (cnt_sat)
            cnt_d = cnt;
        else
            cnt_d = cnt + CNT_W'(1);

        // A timeout wins over a coincident edge, which then restarts measurement.
        if (state != IDLE && cnt_sat) begin
            timeout_d = 1'b1;
            speed_d   = 4'd0;
            locked_d  = 1'b0;
            state_d   = tick_edge ? MEASURE : IDLE;
        end else if (tick_edge) begin
            timeout_d = 1'b0;
            unique case (state)
                IDLE: begin
                    state_d = MEASURE;
                end
                MEASURE: begin
                    speed_d = code;
                    if (code == speed && code >= 4'd1 && code <= 4'd10) begin
                        locked_d = 1'b1;
                        state_d  = LOCKED;
                    end else begin
                        locked_d = 1'b0;
                    end
                end
                LOCKED: begin
                    if (code != speed) begin
                        speed_d  = code;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        HEX5 = 7'b1111111;
        case (speed)
            4'd0:    HEX5 = 7'b0111111;
            4'd1:    HEX5 = 7'b1111001;
            4'd2:    HEX5 = 7'b0100100;
            4'd3:    HEX5 = 7'b0110000;
            4'd4:    HEX5 = 7'b0011001;
            4'd5:    HEX5 = 7'b0010010;
            4'd6:    HEX5 = 7'b0000010;
            4'd7:    HEX5 = 7'b1111000;
            4'd8:    HEX5 = 7'b0000000;
            4'd9:    HEX5 = 7'b0010000;
            4'd10:   HEX5 = 7'b0001000;
            4'd15:   HEX5 = 7'b0001110;
            default: HEX5 = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_rate_meter.sv
// Bench for rate_meter: directed scenarios plus random tick trains, checked against a
// period-counting reference model of the speed/lock/timeout rules.
module tb_rate_meter;

    localparam int BASE = 5120;
    localparam int CW   = 16;
    localparam int TO   = (3 * BASE) >> 1;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       tick_in  = 1'b0;
    logic [3:0] speed;
    logic       locked;
    logic       timeout;
    logic [6:0] HEX5;

    always #5 CLOCK_50 = ~CLOCK_50;

    rate_meter #(.BASE_PERIOD(BASE), .CNT_W(CW)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick_in  (tick_in),
        .speed    (speed),
        .locked   (locked),
        .timeout  (timeout),
        .HEX5     (HEX5)
    );

    int n_pass  = 0;
    int n_total = 0;

    // reference model: measuring flag, reported code, lock, timeout, cycles since last edge
    bit m_active = 0;
    int m_speed  = 0;
    bit m_lock   = 0;
    bit m_to     = 0;
    int m_age    = 0;

    logic [6:0] seg_tab [16];

    function automatic int exp_code(input int p);
        int pk;
        if (4 * p + 4 <= 3 * (BASE >> 9))
            return 15;
        for (int k = 1; k <= 10; k++) begin
            pk = BASE >> (k - 1);
            if (3 * pk < 4 * p + 4 && 2 * p + 2 <= 3 * pk)
                return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " speed"},   32'(speed),   32'(m_speed));
        chk({tag, " locked"},  32'(locked),  32'(m_lock));
        chk({tag, " timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, " hex"},     32'(HEX5),    32'(seg_tab[4'(m_speed)]));
    endtask

    task automatic model_reset();
        m_active = 0;
        m_speed  = 0;
        m_lock   = 0;
        m_to     = 0;
        m_age    = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
            m_age++;
            if (m_active && m_age == TO) begin
                m_to     = 1;
                m_speed  = 0;
                m_lock   = 0;
                m_active = 0;
            end
        end
    endtask

    task automatic model_edge();
        int c;
        if (!m_active) begin
            m_active = 1;
            m_to     = 0;
        end else begin
            c    = exp_code(m_age);
            m_to = 0;
            if (m_lock) begin
                if (c != m_speed) begin
                    m_speed = c;
                    m_lock  = 0;
                end
            end else begin
                if (c == m_speed && c >= 1 && c <= 10)
                    m_lock = 1;
                m_speed = c;
            end
        end
        m_age = 0;
    endtask

    // one tick rising now, high for 'hold' cycles, next rise 'gap' cycles later
    task automatic tick(input int gap, input int hold, input string tag);
        tick_in = 1'b1;
        cyc(1);
        model_edge();
        check_all(tag);
        cyc(hold - 1);
        tick_in = 1'b0;
        cyc(gap - hold);
    endtask

    initial begin
        int g, rep, hold;
        for (int i = 0; i < 16; i++) seg_tab[i] = 7'b1111111;
        seg_tab[0]  = 7'b0111111;
        seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001;
        seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010;
        seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000;
        seg_tab[15] = 7'b0001110;

        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_all("reset");
        reset = 1'b0;

        // steady 320-cycle ticks: code 5 after 2nd edge, lock after 3rd
        tick(320, 1, "r25_e1");
        tick(320, 1, "r25_e2");
        chk("r25 speed5", 32'(speed), 32'd5);
        chk("r25 hex5", 32'(HEX5), 32'(7'b0010010));
        tick(320, 1, "r25_e3");
        chk("r25 lock", 32'(locked), 32'd1);

        // fastest band then too fast
        for (int i = 0; i < 4; i++) tick(10, 1, "r26_10");
        chk("r26 speed10", 32'(speed), 32'd10);
        chk("r26 lock10", 32'(locked), 32'd1);
        for (int i = 0; i < 3; i++) tick(6, 1, "r26_6");
        chk("r26 speed15", 32'(speed), 32'd15);
        chk("r26 hexF", 32'(HEX5), 32'(7'b0001110));
        chk("r26 nolock15", 32'(locked), 32'd0);

        // band boundaries around code 5
        tick(240, 1, "r27_a");
        tick(239, 1, "r27_b");
        chk("r27 p240", 32'(speed), 32'd5);
        tick(479, 1, "r27_c");
        chk("r27 p239", 32'(speed), 32'd6);
        tick(480, 1, "r27_d");
        chk("r27 p479", 32'(speed), 32'd5);
        tick(300, 1, "r27_e");
        chk("r27 p480", 32'(speed), 32'd4);

        // lock on code 3, then starve ticks until timeout
        for (int i = 0; i < 4; i++) tick(1280, 1, "r28_lock");
        chk("r28 speed3", 32'(speed), 32'd3);
        chk("r28 lock3", 32'(locked), 32'd1);
        cyc(6500);
        check_all("r28_starved");
        chk("r28 timeout", 32'(timeout), 32'd1);
        chk("r28 dash", 32'(HEX5), 32'(7'b0111111));
        tick(640, 1, "r28_restart");
        chk("r28 to_clear", 32'(timeout), 32'd0);

        // lock on code 4, then asynchronous reset mid-period
        tick(640, 1, "r29_a");
        tick(640, 1, "r29_b");
        chk("r29 locked", 32'(locked), 32'd1);
        cyc(200);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("r29_async");
        chk("r29 speed0", 32'(speed), 32'd0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        tick(640, 1, "r29_e1");
        tick(640, 1, "r29_e2");
        chk("r29 e2 nolock", 32'(locked), 32'd0);
        tick(640, 1, "r29_e3");
        chk("r29 e3 lock", 32'(locked), 32'd1);

        // long high level counts once per period
        for (int i = 0; i < 4; i++) tick(640, 50, "r30_level");
        chk("r30 speed4", 32'(speed), 32'd4);
        chk("r30 lock", 32'(locked), 32'd1);

        // random tick trains, each gap repeated a few times so locks occur
        for (int i = 0; i < 25; i++) begin
            g    = $urandom_range(1500, 3);
            rep  = $urandom_range(3, 1);
            hold = $urandom_range((g - 1 < 20) ? g - 1 : 20, 1);
            for (int r = 0; r < rep; r++) tick(g, hold, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
